// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment display path.
//
// Contents:
//   NUM_DIGITS                      number of scanned digits (8)
//   DEF_REFRESH_DIV                 default clock cycles per digit slot
//   DEF_BLANK_CYCLES                default blanked cycles at each slot start
//   nibble_t                        one hex digit
//   scan_state_t                    BLANK / DRIVE scan phase
//   digit_sel()                     picks nibble k out of a 32-bit display word
//   anode_sel()                     active-low one-hot anode pattern for digit k
package seg7_pkg;

  localparam int NUM_DIGITS       = 8;
  localparam int DEF_REFRESH_DIV  = 100000;
  localparam int DEF_BLANK_CYCLES = 2;

  typedef logic [3:0] nibble_t;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // Nibble k lives at word[4k+3:4k]; digit 0 is the rightmost.
  function automatic nibble_t digit_sel(input logic [31:0] word, input logic [2:0] k);
    return word[{k, 2'b00} +: 4];
  endfunction

  function automatic logic [7:0] anode_sel(input logic [2:0] k);
    return ~(8'h01 << k);
  endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Modulo-N free-running counter with a terminal-count flag.
// Reusable for any display timing that needs a fixed slot length.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset (count returns to 0)
//   cnt_o  out  current count, 0..N-1
//   tc_o   out  high while cnt_o == N-1; the next edge wraps the count to 0
module seg7_prescaler #(
  parameter int N = 100000,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         tc;

  assign tc = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (tc) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = tc;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an eight-digit seven-segment display.
// Holds a 32-bit display word, steps through the digits at a fixed slot rate,
// presents the current nibble on binNumber for the external encoder stage and
// drives the active-low anodes and decimal point.
//
// Each slot starts with BLANK_CYCLES cycles of all anodes off so the clocked
// encoder has settled on the new nibble before the digit lights (no ghosting).
//
// Interface protocol: there is no valid/ready handshake. `load` is a
// single-cycle strobe that is always accepted; it captures digits/digit_en/
// dp_mask into a pending register (last load wins). Pending data moves to the
// active register only on the digit 7->0 wrap edge, so a frame never tears.
// All outputs are continuous and registered.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   digits       in   32  display data, nibble k = digits[4k+3:4k]
//   digit_en     in   8   per-digit enable (0 blanks that digit)
//   dp_mask      in   8   per-digit decimal point (1 lights it)
//   load         in   1   capture strobe for the three inputs above
//   binNumber    out  4   nibble for the encoder, updates at slot start
//   anode        out  8   active-low digit select
//   dp_n         out  1   active-low decimal point
//   frame_start  out  1   one-cycle pulse after the scan wraps to digit 0
//   dbg_state_o  out      current scan phase, for observation only
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = DEF_REFRESH_DIV,  // >= BLANK_CYCLES + 2
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES  // >= 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] digits,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp_mask,
  input  logic        load,
  output nibble_t     binNumber,
  output logic [7:0]  anode,
  output logic        dp_n,
  output logic        frame_start,
  output scan_state_t dbg_state_o
);

  localparam int                CNT_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             tc;
  logic             wrap;

  scan_state_t state_q, state_d;
  logic [2:0]  idx_q, idx_d;

  logic [31:0] act_digits_q, act_digits_d;
  logic [7:0]  act_en_q, act_en_d;
  logic [7:0]  act_dp_q, act_dp_d;

  logic [31:0] pend_digits_q, pend_digits_d;
  logic [7:0]  pend_en_q, pend_en_d;
  logic [7:0]  pend_dp_q, pend_dp_d;
  logic        pend_valid_q, pend_valid_d;

  nibble_t     bin_q, bin_d;
  logic [7:0]  anode_q, anode_d;
  logic        dp_n_q, dp_n_d;
  logic        frame_q, frame_d;

  seg7_prescaler #(
    .N (REFRESH_DIV),
    .W (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .cnt_o (cnt),
    .tc_o  (tc)
  );

  assign wrap = tc && (idx_q == 3'd7);

  // Digit index, pending/active data registers.
  always_comb begin
    idx_d = idx_q;
    if (tc) begin
      idx_d = idx_q + 3'd1;
    end

    act_digits_d = act_digits_q;
    act_en_d     = act_en_q;
    act_dp_d     = act_dp_q;
    if (wrap && pend_valid_q) begin
      act_digits_d = pend_digits_q;
      act_en_d     = pend_en_q;
      act_dp_d     = pend_dp_q;
    end

    // A load on the wrap edge lands in pending after the old pending data
    // has been committed, so it waits for the following wrap.
    pend_digits_d = pend_digits_q;
    pend_en_d     = pend_en_q;
    pend_dp_d     = pend_dp_q;
    pend_valid_d  = pend_valid_q;
    if (load) begin
      pend_digits_d = digits;
      pend_en_d     = digit_en;
      pend_dp_d     = dp_mask;
      pend_valid_d  = 1'b1;
    end else if (wrap) begin
      pend_valid_d = 1'b0;
    end
  end

  // Scan FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BLANK: begin
        if (!tc && (cnt == BLANK_LAST)) begin
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (tc) begin
          state_d = BLANK;
        end
      end
      default: state_d = BLANK;
    endcase
  end

  // Outputs are computed from next-state values so the registered outputs
  // line up with the state they describe.
  always_comb begin
    bin_d = bin_q;
    if (tc) begin
      bin_d = digit_sel(act_digits_d, idx_d);
    end

    anode_d = 8'hFF;
    dp_n_d  = 1'b1;
    if ((state_d == DRIVE) && act_en_d[idx_d]) begin
      anode_d = anode_sel(idx_d);
      dp_n_d  = ~act_dp_d[idx_d];
    end

    frame_d = wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BLANK;
      idx_q         <= 3'd0;
      act_digits_q  <= '0;
      act_en_q      <= '0;
      act_dp_q      <= '0;
      pend_digits_q <= '0;
      pend_en_q     <= '0;
      pend_dp_q     <= '0;
      pend_valid_q  <= 1'b0;
      bin_q         <= '0;
      anode_q       <= 8'hFF;
      dp_n_q        <= 1'b1;
      frame_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      act_digits_q  <= act_digits_d;
      act_en_q      <= act_en_d;
      act_dp_q      <= act_dp_d;
      pend_digits_q <= pend_digits_d;
      pend_en_q     <= pend_en_d;
      pend_dp_q     <= pend_dp_d;
      pend_valid_q  <= pend_valid_d;
      bin_q         <= bin_d;
      anode_q       <= anode_d;
      dp_n_q        <= dp_n_d;
      frame_q       <= frame_d;
    end
  end

  assign binNumber   = bin_q;
  assign anode       = anode_q;
  assign dp_n        = dp_n_q;
  assign frame_start = frame_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl with REFRESH_DIV=8, BLANK_CYCLES=2.
// A reference model derives every expected output from the edge count since
// reset (slot = edges/8, position in slot = edges%8, frame = 64 edges) and the
// committed display data; expectations are queued at each rising edge and a
// monitor pops and compares them on the falling edge.
module tb_seg7_scan_ctrl;
  import seg7_pkg::*;

  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = RD * NUM_DIGITS;
  localparam int EW    = 14;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] digits;
  logic [7:0]  digit_en;
  logic [7:0]  dp_mask;
  logic        load;
  nibble_t     binNumber;
  logic [7:0]  anode;
  logic        dp_n;
  logic        frame_start;
  scan_state_t dbg_state;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .digits      (digits),
    .digit_en    (digit_en),
    .dp_mask     (dp_mask),
    .load        (load),
    .binNumber   (binNumber),
    .anode       (anode),
    .dp_n        (dp_n),
    .frame_start (frame_start),
    .dbg_state_o (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int            edge_cnt = 0;
  logic [31:0]   m_act_d, m_pend_d;
  logic [7:0]    m_act_en, m_act_dp, m_pend_en, m_pend_dp;
  logic          m_pend_valid;

  always @(posedge clk) begin
    int      idx, pos;
    nibble_t nib;
    logic    lit;
    logic [7:0] an;
    if (rst) begin
      edge_cnt     = 0;
      m_act_d      = '0; m_act_en  = '0; m_act_dp  = '0;
      m_pend_d     = '0; m_pend_en = '0; m_pend_dp = '0;
      m_pend_valid = 1'b0;
      exp_q.push_back({4'h0, 8'hFF, 1'b1, 1'b0});
    end else begin
      edge_cnt++;
      if ((edge_cnt % FRAME == 0) && m_pend_valid) begin
        m_act_d = m_pend_d; m_act_en = m_pend_en; m_act_dp = m_pend_dp;
        m_pend_valid = 1'b0;
      end
      if (load) begin
        m_pend_d = digits; m_pend_en = digit_en; m_pend_dp = dp_mask;
        m_pend_valid = 1'b1;
      end
      idx = (edge_cnt / RD) % NUM_DIGITS;
      pos = edge_cnt % RD;
      nib = 4'((m_act_d >> (4 * idx)) & 32'hF);
      lit = (pos >= BC) && m_act_en[idx];
      an  = lit ? ~(8'h01 << idx) : 8'hFF;
      exp_q.push_back({nib, an, ~(lit && m_act_dp[idx]), (edge_cnt % FRAME == 0)});
    end
  end

  logic watch_a = 1'b0;
  logic saw_a   = 1'b0;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("binNumber",   32'(binNumber),   32'(e[13:10]));
      check("anode",       32'(anode),       32'(e[9:2]));
      check("dp_n",        32'(dp_n),        32'(e[1]));
      check("frame_start", 32'(frame_start), 32'(e[0]));
      if (watch_a && (anode !== 8'hFF) && (binNumber === 4'hA)) saw_a = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_load(input logic [31:0] d, input logic [7:0] en, input logic [7:0] dp);
    @(posedge clk); #2;
    digits = d; digit_en = en; dp_mask = dp; load = 1'b1;
    @(posedge clk); #2;
    load = 1'b0;
  endtask

  // Returns at posedge+2 once the model's edge count is m modulo a frame.
  task automatic wait_mod(input int m);
    int guard = 0;
    do begin
      @(posedge clk); #2;
      guard++;
    end while ((edge_cnt % FRAME != m) && (guard < 4 * FRAME));
    check("wait_mod", 32'(edge_cnt % FRAME), 32'(m));
  endtask

  // Drive load so that it is sampled on the edge numbered s within the frame.
  task automatic load_at(input int s, input logic [31:0] d, input logic [7:0] en,
                         input logic [7:0] dp);
    wait_mod((s + FRAME - 1) % FRAME);
    digits = d; digit_en = en; dp_mask = dp; load = 1'b1;
    @(posedge clk); #2;
    load = 1'b0;
  endtask

  task automatic wait_fs(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (!frame_start && (cycles < budget));
    if (!frame_start) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_start_timeout: no pulse within %0d cycles", budget);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p;
    rst = 1'b1; load = 1'b0; digits = '0; digit_en = '0; dp_mask = '0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_anode", 32'(anode), 32'hFF);
    check("reset_bin",   32'(binNumber), 32'h0);
    check("reset_dp_n",  32'(dp_n), 32'h1);
    check("reset_fs",    32'(frame_start), 32'h0);
    rst = 1'b0;

    // 1: basic scan and frame period
    do_load(32'h7654_3210, 8'hFF, 8'h00);
    wait_fs(2 * FRAME, p);
    wait_fs(2 * FRAME, p);
    check("frame_period", 32'(p), 32'(FRAME));
    repeat (FRAME) @(posedge clk);

    // 2: sparse digit enables
    do_load(32'h7654_3210, 8'b1010_0101, 8'h00);
    repeat (2 * FRAME) @(posedge clk);

    // 3: decimal point on digit 7 only
    do_load(32'h7654_3210, 8'hFF, 8'h80);
    repeat (2 * FRAME) @(posedge clk);

    // 4: last load before the wrap wins, the overwritten pattern never shows
    watch_a = 1'b1;
    load_at(26, 32'hAAAA_AAAA, 8'hFF, 8'h00);
    load_at(42, 32'h5555_5555, 8'hFF, 8'h00);
    repeat (2 * FRAME) @(posedge clk);
    watch_a = 1'b0;
    check("a_never_shown", 32'(saw_a), 32'h0);

    // 5: earlier pending load commits at the wrap, load on the wrap edge waits a frame
    load_at(10, 32'h1111_1111, 8'hFF, 8'h00);
    load_at(0,  32'h89AB_CDEF, 8'hFF, 8'h01);
    check("wrap_commit_old", 32'(binNumber), 32'h1);
    repeat (FRAME) @(posedge clk);
    #2;
    check("wrap_load_next_frame", 32'(binNumber), 32'hF);

    // 6: async reset in the DRIVE phase of digit 4 with a load still pending
    load_at(34, 32'hFFFF_FFFF, 8'hFF, 8'hFF);
    wait_mod(36);
    check("pre_reset_anode", 32'(anode), 32'hEF);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("async_anode", 32'(anode), 32'hFF);
    check("async_bin",   32'(binNumber), 32'h0);
    check("async_dp_n",  32'(dp_n), 32'h1);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    repeat (FRAME + RD) @(posedge clk);

    // random loads at random times
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(1, 40)) @(posedge clk);
      do_load($urandom, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    repeat (2 * FRAME + 4) @(posedge clk);
    @(negedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for the eight-digit seven-segment display. Holds a 32-bit display word (eight 4-bit digits), steps through the digits at a fixed refresh rate, and presents one nibble at a time to the `encoder` stage through `binNumber`. It also drives the active-low digit anodes and the decimal point. Anode enable is delayed behind the nibble update so the clocked encoder's cathode output has settled before a digit lights, which prevents ghosting.

## Interface
- `REFRESH_DIV`, 100000: clock cycles per digit slot (1 kHz slot rate at 100 MHz). Must be ≥ `BLANK_CYCLES`+2.
- `BLANK_CYCLES`, 2: cycles at the start of each slot with all anodes off. Must be ≥ 1.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `digits`  in  32  display data; nibble k = `digits[4k+3:4k]`, digit 0 rightmost.
- `digit_en`  in  8  per-digit enable; 0 blanks the digit.
- `dp_mask`  in  8  per-digit decimal point; 1 lights the DP.
- `load`  in  1  single-cycle strobe; captures `digits`/`digit_en`/`dp_mask`.
- `binNumber`  out  4  nibble feeding the `encoder` stage.
- `anode`  out  8  active-low digit select.
- `dp_n`  out  1  active-low decimal point.
- `frame_start`  out  1  one-cycle pulse when the scan returns to digit 0.

## Operation
- Pending register: `load` copies all three inputs into a pending register and sets `pend_valid`. A second `load` before commit overwrites the pending data; the last load wins.
- Commit: pending data is copied to the active register only on the digit-7→0 wrap edge, which clears `pend_valid`. A `load` on that same edge goes to the pending register and commits on the next wrap, so frames never tear.
- Prescaler: `cnt` counts 0..`REFRESH_DIV`-1. At terminal count, `cnt` returns to 0 and `idx` (0..7) increments; 7 wraps to 0.
- FSM states:
  - BLANK: `anode`=FF, `dp_n`=1. Moves to DRIVE when `cnt`==`BLANK_CYCLES`-1.
  - DRIVE: `anode`=~(1<<idx) if `digit_en[idx]`, else FF. `dp_n`=~(`dp_mask[idx]` & `digit_en[idx]`). Moves to BLANK at terminal count.
- `binNumber` = active nibble[idx], registered. It updates on the same edge `idx` changes and holds for the whole slot.
- `frame_start` is asserted, registered, on the cycle after the edge where `idx` becomes 0.
- All outputs are registered and glitch-free. Only one anode bit is ever low.

## Timing
- Reset values: `anode`=8'hFF, `dp_n`=1, `binNumber`=0, `frame_start`=0.
- Reset internal state: `cnt`=0, `idx`=0, state BLANK, active and pending registers 0, `pend_valid`=0.
- The first slot after reset release is digit 0. Its anode goes low `BLANK_CYCLES` cycles after the first clock edge.
- Slot k: the edge starting the slot updates `idx`/`binNumber` and forces `anode`=FF. The anode asserts `BLANK_CYCLES` edges later and stays low for `REFRESH_DIV`-`BLANK_CYCLES` cycles.
- Full frame = 8×`REFRESH_DIV` cycles. `frame_start` period is exactly that.
- Load to visible latency ranges from 1 cycle after the next wrap up to one frame plus 1 cycle.
- `rst` mid-slot: outputs go to reset values immediately (asynchronous). Pending data is discarded.
- `digit_en`=0 for every digit: `anode` stays FF while the scan keeps running and `frame_start` keeps pulsing.

## Structure
- Package `seg7_pkg`:
  - `NUM_DIGITS`=8.
  - `typedef logic [3:0] nibble_t`.
  - Scan-state enum `scan_state_t {BLANK, DRIVE}`.
  - Default `REFRESH_DIV`/`BLANK_CYCLES` constants.
- One sub-module `seg7_prescaler`: parameterised modulo-N counter with a terminal-count pulse, reusable by other display timing.
- The `encoder` is instantiated alongside this block by the top level, not inside it.

## Test plan
All scenarios use `REFRESH_DIV`=8, `BLANK_CYCLES`=2.
1. Reset then `load` `digits`=32'h76543210, `digit_en`=FF, `dp_mask`=0 → after the first wrap, `binNumber` steps 0,1..7 every 8 cycles. `anode` is FF for 2 cycles and then FE, FD..7F for 6 cycles. `frame_start` period is 64.
2. `digit_en`=8'b1010_0101 → digits 1, 3, 4, 6 keep `anode`=FF for their entire slot. `binNumber` still steps through all 8 digits.
3. `dp_mask`=8'h80 → `dp_n`=0 only during the DRIVE phase of digit 7. `dp_n` is 1 during every BLANK phase.
4. `load` of 32'hAAAAAAAA during the digit-3 slot, then `load` of 32'h5555_5555 during digit 5 → digits 4–7 still show the old data. The next frame shows only 5s; the A pattern is never displayed.
5. `load` on the exact digit-7→0 wrap edge → data appears one full frame later. An unrelated earlier pending load commits at that wrap.
6. Assert `rst` during the DRIVE phase of digit 4 → `anode`=FF and `binNumber`=0 within the same cycle, before any clock edge. After release, the scan restarts at digit 0 with blank display data.
